// File: rtl/beat_interval_meter.sv
// -----------------------------------------------------------------------------
// beat_interval_meter
//
// Turns raw peak flags into validated heartbeats, blanks a refractory window
// after each accepted beat, measures the inter-beat interval (IBI) in sample
// ticks, keeps a 4-beat running average and flags loss of signal on timeout.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   peak       in   peak flag (level or pulse), synchronous to clk
//   clr        in   synchronous soft clear, same effect as rst
//   beat       out  one-cycle pulse per accepted beat
//   ibi        out  last measured interval in ticks (holds)
//   ibi_valid  out  one-cycle pulse, coincident with beat, when ibi updates
//   ibi_avg    out  (sum of last 4 intervals) >> 2
//   avg_valid  out  high once 4 intervals collected since IDLE
//   lost       out  high after a timeout, cleared by the next accepted beat
//   beat_cnt   out  accepted-beat counter, wraps 255 -> 0
//   state_dbg  out  current FSM state (IDLE=0, REFRACT=1, LISTEN=2)
//
// Output protocol: there is no backpressure. beat and ibi_valid are single
// cycle strobes that appear in the cycle after the clock edge that sampled
// the rising edge of peak; ibi, ibi_avg, avg_valid and lost are levels that
// are stable whenever a strobe is high and hold until the next update.
// -----------------------------------------------------------------------------
module beat_interval_meter #(
   parameter int TICK_DIV = 1000,
   parameter int IBI_W    = 12,
   parameter int REFRACT  = 50,
   parameter int TIMEOUT  = 3000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             peak,
   input  logic             clr,
   output logic             beat,
   output logic [IBI_W-1:0] ibi,
   output logic             ibi_valid,
   output logic [IBI_W-1:0] ibi_avg,
   output logic             avg_valid,
   output logic             lost,
   output logic [7:0]       beat_cnt,
   output logic [1:0]       state_dbg
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int REF_W = $clog2(REFRACT + 1);
   localparam int SUM_W = IBI_W + 2;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REFRACT = 2'd1;
   localparam logic [1:0] ST_LISTEN  = 2'd2;

   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(TICK_DIV - 1);
   localparam logic [REF_W-1:0] REF_LAST_M1 = REF_W'(REFRACT - 1);
   localparam logic [IBI_W-1:0] CNT_MAX     = '1;
   localparam logic [IBI_W-1:0] TIMEOUT_C   = IBI_W'(TIMEOUT);

   logic [1:0]            state_q, state_d;
   logic                  peak_q, peak_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [IBI_W-1:0]      ibi_cnt_q, ibi_cnt_d;
   logic [REF_W-1:0]      ref_cnt_q, ref_cnt_d;
   logic [3:0][IBI_W-1:0] win_q, win_d;
   logic [2:0]            fill_q, fill_d;
   logic [SUM_W-1:0]      sum_q, sum_d;
   logic                  beat_q, beat_d;
   logic [IBI_W-1:0]      ibi_q, ibi_d;
   logic                  ibi_valid_q, ibi_valid_d;
   logic [IBI_W-1:0]      ibi_avg_q, ibi_avg_d;
   logic                  avg_valid_q, avg_valid_d;
   logic                  lost_q, lost_d;
   logic [7:0]            beat_cnt_q, beat_cnt_d;

   logic                  rise;
   logic                  tick;
   logic [IBI_W-1:0]      cnt_inc;
   logic [SUM_W-1:0]      sum_push;

   always_comb begin
      rise    = peak & ~peak_q;
      tick    = (div_q == DIV_LAST);
      cnt_inc = (ibi_cnt_q == CNT_MAX) ? ibi_cnt_q : ibi_cnt_q + 1'b1;
      // Running window sum: add the entry being pushed, drop the one falling
      // out of the oldest slot. Empty slots hold 0, so this stays exact.
      sum_push = sum_q + {2'b00, ibi_cnt_q} - {2'b00, win_q[3]};

      state_d     = state_q;
      peak_d      = peak;
      div_d       = tick ? '0 : div_q + 1'b1;
      ibi_cnt_d   = ibi_cnt_q;
      ref_cnt_d   = ref_cnt_q;
      win_d       = win_q;
      fill_d      = fill_q;
      sum_d       = sum_q;
      beat_d      = 1'b0;
      ibi_d       = ibi_q;
      ibi_valid_d = 1'b0;
      ibi_avg_d   = ibi_avg_q;
      avg_valid_d = avg_valid_q;
      lost_d      = lost_q;
      beat_cnt_d  = beat_cnt_q;

      case (state_q)
         ST_IDLE: begin
            ibi_cnt_d = '0;
            if (rise) begin
               beat_d     = 1'b1;
               beat_cnt_d = beat_cnt_q + 1'b1;
               lost_d     = 1'b0;
               ref_cnt_d  = '0;
               state_d    = ST_REFRACT;
            end
         end
         ST_REFRACT: begin
            // Peak edges are blanked here; only time advances.
            if (tick) begin
               ibi_cnt_d = cnt_inc;
               ref_cnt_d = ref_cnt_q + 1'b1;
               if (ref_cnt_q == REF_LAST_M1) begin
                  state_d = ST_LISTEN;
               end
            end
         end
         ST_LISTEN: begin
            // A rise takes priority over both the tick and the timeout, so
            // ibi captures the count as it stood before this edge.
            if (rise) begin
               beat_d      = 1'b1;
               ibi_valid_d = 1'b1;
               ibi_d       = ibi_cnt_q;
               win_d       = {win_q[2:0], ibi_cnt_q};
               sum_d       = sum_push;
               ibi_avg_d   = sum_push[SUM_W-1:2];
               fill_d      = (fill_q == 3'd4) ? 3'd4 : fill_q + 1'b1;
               avg_valid_d = (fill_q >= 3'd3);
               ibi_cnt_d   = '0;
               ref_cnt_d   = '0;
               beat_cnt_d  = beat_cnt_q + 1'b1;
               state_d     = ST_REFRACT;
            end else if (ibi_cnt_q >= TIMEOUT_C) begin
               lost_d      = 1'b1;
               win_d       = '0;
               sum_d       = '0;
               fill_d      = '0;
               avg_valid_d = 1'b0;
               ibi_avg_d   = '0;
               ibi_cnt_d   = '0;
               state_d     = ST_IDLE;
            end else if (tick) begin
               ibi_cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            ibi_cnt_d = '0;
         end
      endcase

      // Soft clear overrides everything computed above, including a
      // same-cycle rise.
      if (clr) begin
         state_d     = ST_IDLE;
         peak_d      = 1'b0;
         div_d       = '0;
         ibi_cnt_d   = '0;
         ref_cnt_d   = '0;
         win_d       = '0;
         fill_d      = '0;
         sum_d       = '0;
         beat_d      = 1'b0;
         ibi_d       = '0;
         ibi_valid_d = 1'b0;
         ibi_avg_d   = '0;
         avg_valid_d = 1'b0;
         lost_d      = 1'b0;
         beat_cnt_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         peak_q      <= 1'b0;
         div_q       <= '0;
         ibi_cnt_q   <= '0;
         ref_cnt_q   <= '0;
         win_q       <= '0;
         fill_q      <= '0;
         sum_q       <= '0;
         beat_q      <= 1'b0;
         ibi_q       <= '0;
         ibi_valid_q <= 1'b0;
         ibi_avg_q   <= '0;
         avg_valid_q <= 1'b0;
         lost_q      <= 1'b0;
         beat_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         peak_q      <= peak_d;
         div_q       <= div_d;
         ibi_cnt_q   <= ibi_cnt_d;
         ref_cnt_q   <= ref_cnt_d;
         win_q       <= win_d;
         fill_q      <= fill_d;
         sum_q       <= sum_d;
         beat_q      <= beat_d;
         ibi_q       <= ibi_d;
         ibi_valid_q <= ibi_valid_d;
         ibi_avg_q   <= ibi_avg_d;
         avg_valid_q <= avg_valid_d;
         lost_q      <= lost_d;
         beat_cnt_q  <= beat_cnt_d;
      end
   end

   assign beat      = beat_q;
   assign ibi       = ibi_q;
   assign ibi_valid = ibi_valid_q;
   assign ibi_avg   = ibi_avg_q;
   assign avg_valid = avg_valid_q;
   assign lost      = lost_q;
   assign beat_cnt  = beat_cnt_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_beat_interval_meter.sv
// -----------------------------------------------------------------------------
// tb_beat_interval_meter
//
// Directed bench for beat_interval_meter with TICK_DIV=4, REFRACT=5,
// TIMEOUT=40, IBI_W=8. Peak rises are driven on the falling edge so the DUT
// samples them on the next rising edge. Rise-sampling edges are kept at a
// divider phase that is not a tick edge (except in the rise/tick collision
// step), so an interval of N*4 clocks measures exactly N ticks.
// -----------------------------------------------------------------------------
module tb_beat_interval_meter;

   localparam int TICK_DIV = 4;
   localparam int IBI_W    = 8;
   localparam int REFRACT  = 5;
   localparam int TIMEOUT  = 40;
   localparam int EXP_W    = 2 + IBI_W + 8 + 1 + IBI_W + 1;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic peak = 1'b0;
   logic clr = 1'b0;

   always #5 clk = ~clk;

   logic             beat;
   logic [IBI_W-1:0] ibi;
   logic             ibi_valid;
   logic [IBI_W-1:0] ibi_avg;
   logic             avg_valid;
   logic             lost;
   logic [7:0]       beat_cnt;
   logic [1:0]       state_dbg;

   beat_interval_meter #(
      .TICK_DIV (TICK_DIV),
      .IBI_W    (IBI_W),
      .REFRACT  (REFRACT),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .peak      (peak),
      .clr       (clr),
      .beat      (beat),
      .ibi       (ibi),
      .ibi_valid (ibi_valid),
      .ibi_avg   (ibi_avg),
      .avg_valid (avg_valid),
      .lost      (lost),
      .beat_cnt  (beat_cnt),
      .state_dbg (state_dbg)
   );

   // scoreboard
   int n_cmp = 0;
   int n_err = 0;
   logic [EXP_W-1:0] exp_q[$];

   // reference state of the outputs
   logic [IBI_W-1:0] m_ibi;
   logic [7:0]       m_cnt;
   int               m_win[4];
   int               m_fill;
   logic             m_avgv;
   logic [IBI_W-1:0] m_avg;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ibi  = '0;
      m_cnt  = '0;
      m_fill = 0;
      m_avgv = 1'b0;
      m_avg  = '0;
      for (int i = 0; i < 4; i++) m_win[i] = 0;
   endtask

   task automatic model_timeout();
      m_fill = 0;
      m_avgv = 1'b0;
      m_avg  = '0;
      for (int i = 0; i < 4; i++) m_win[i] = 0;
   endtask

   // expected output bundle: {beat, ibi_valid, ibi, beat_cnt, avg_valid, ibi_avg, lost}
   task automatic exp_first();
      m_cnt = m_cnt + 8'd1;
      exp_q.push_back({1'b1, 1'b0, m_ibi, m_cnt, m_avgv, m_avg, 1'b0});
   endtask

   task automatic exp_interval(input int iv);
      int sum;
      m_cnt = m_cnt + 8'd1;
      m_ibi = IBI_W'(iv);
      for (int i = 3; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = iv;
      sum = m_win[0] + m_win[1] + m_win[2] + m_win[3];
      m_avg  = IBI_W'(sum >> 2);
      m_fill = (m_fill < 4) ? m_fill + 1 : 4;
      m_avgv = (m_fill == 4);
      exp_q.push_back({1'b1, 1'b1, m_ibi, m_cnt, m_avgv, m_avg, 1'b0});
   endtask

   // driver tasks
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // peak high for exactly one rising edge
   task automatic drive_rise();
      peak = 1'b1;
      @(negedge clk);
      peak = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_beat"},      32'(beat),      0);
      check({tag, "_ibi"},       32'(ibi),       0);
      check({tag, "_ibi_valid"}, 32'(ibi_valid), 0);
      check({tag, "_ibi_avg"},   32'(ibi_avg),   0);
      check({tag, "_avg_valid"}, 32'(avg_valid), 0);
      check({tag, "_lost"},      32'(lost),      0);
      check({tag, "_beat_cnt"},  32'(beat_cnt),  0);
      check({tag, "_state"},     32'(state_dbg), 0);
   endtask

   // monitor: every strobe must match the next queued expectation
   always @(negedge clk) begin
      if (!rst && (beat || ibi_valid)) begin
         n_cmp++;
         assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL unexpected_beat: observed beat=%0b ibi_valid=%0b ibi=%0d beat_cnt=%0d expected no strobe",
                   beat, ibi_valid, ibi, beat_cnt);
         end
         if (exp_q.size() != 0) begin
            logic [EXP_W-1:0] e;
            logic [EXP_W-1:0] o;
            e = exp_q.pop_front();
            o = {beat, ibi_valid, ibi, beat_cnt, avg_valid, ibi_avg, lost};
            n_cmp++;
            assert (o === e) else begin
               n_err++;
               $error("FAIL beat_bundle: observed v=%0b ibi=%0d cnt=%0d avgv=%0b avg=%0d lost=%0b expected v=%0b ibi=%0d cnt=%0d avgv=%0b avg=%0d lost=%0b",
                      o[EXP_W-2], o[EXP_W-3 -: IBI_W], o[EXP_W-3-IBI_W -: 8], o[IBI_W+1], o[IBI_W:1], o[0],
                      e[EXP_W-2], e[EXP_W-3 -: IBI_W], e[EXP_W-3-IBI_W -: 8], e[IBI_W+1], e[IBI_W:1], e[0]);
            end
         end
      end
   end

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: observed time limit reached, expected end of sequence");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // first beat then a 12-tick interval
      idle(10);
      exp_first();
      drive_rise();
      idle(47);
      exp_interval(12);
      drive_rise();
      idle(47);
      exp_interval(12);
      drive_rise();

      // asynchronous reset while listening
      idle(30);
      check("pre_rst_state", 32'(state_dbg), 2);
      check("pre_rst_ibi", 32'(ibi), 12);
      check("pre_rst_cnt", 32'(beat_cnt), 3);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // first beat after reset, refractory rise, then a 10-tick interval
      idle(2);
      exp_first();
      drive_rise();
      idle(11);
      drive_rise();
      check("refract_cnt", 32'(beat_cnt), 1);
      idle(27);
      exp_interval(10);
      drive_rise();

      // peak held high for 100 clocks -> one beat
      idle(39);
      exp_interval(10);
      peak = 1'b1;
      repeat (100) @(negedge clk);
      peak = 1'b0;
      check("hold_cnt", 32'(beat_cnt), 3);

      // timeout: count reaches 40 at +157, lost at +158
      idle(58);
      check("pre_timeout_lost", 32'(lost), 0);
      check("pre_timeout_state", 32'(state_dbg), 2);
      idle(1);
      model_timeout();
      check("timeout_lost", 32'(lost), 1);
      check("timeout_avg_valid", 32'(avg_valid), 0);
      check("timeout_ibi_avg", 32'(ibi_avg), 0);
      check("timeout_ibi", 32'(ibi), 10);
      check("timeout_state", 32'(state_dbg), 0);

      idle(9);
      exp_first();
      drive_rise();
      check("relock_lost", 32'(lost), 0);

      // averaging window
      idle(39); exp_interval(10); drive_rise();
      idle(47); exp_interval(12); drive_rise();
      idle(55); exp_interval(14); drive_rise();
      check("avg_valid_3", 32'(avg_valid), 0);
      idle(63); exp_interval(16); drive_rise();
      check("avg_valid_4", 32'(avg_valid), 1);
      check("ibi_avg_4", 32'(ibi_avg), 13);
      idle(79); exp_interval(20); drive_rise();
      check("ibi_avg_5", 32'(ibi_avg), 15);

      // rise on the very edge the timeout would fire
      idle(157);
      exp_interval(40);
      drive_rise();
      check("edge_timeout_lost", 32'(lost), 0);

      // rise on a tick edge: pre-increment count captured, counter restarts at 0
      idle(42);
      exp_interval(10);
      drive_rise();
      idle(31);
      exp_interval(7);
      drive_rise();

      // clr together with a rise: clr wins
      idle(20);
      clr  = 1'b1;
      peak = 1'b1;
      @(negedge clk);
      clr  = 1'b0;
      peak = 1'b0;
      model_reset();
      check_all_zero("clr");
      idle(1);
      exp_first();
      drive_rise();

      idle(4);
      check("queue_empty", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/beat_interval_meter.md
Name: beat_interval_meter

Overview:
- Downstream consumer of th_flt's peak output.
- Turns raw peak pulses into validated heartbeats and applies a refractory blanking window.
- Measures the inter-beat interval (IBI) in sample ticks and keeps a 4-beat running average.
- Flags loss of signal when no beat arrives within a timeout.

Parameters:
- TICK_DIV, 1000: clk cycles per sample tick; must be >= 1.
- IBI_W, 12: width of interval counters and outputs.
- REFRACT, 50: ticks after an accepted beat during which peak edges are ignored; must be >= 1.
- TIMEOUT, 3000: ticks without a beat before lost asserts; must be > REFRACT and <= 2^IBI_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- peak  in  1  peak flag from th_flt, synchronous to clk; level or pulse.
- clr  in  1  synchronous soft clear; same effect as rst, applied at the clock edge.
- beat  out  1  one-cycle pulse per accepted beat.
- ibi  out  IBI_W  last measured interval in ticks; holds until the next measurement.
- ibi_valid  out  1  one-cycle pulse, coincident with beat, when ibi is updated.
- ibi_avg  out  IBI_W  average of the last 4 intervals (sum>>2, truncating).
- avg_valid  out  1  level; high once 4 intervals have been collected since IDLE.
- lost  out  1  level; high after a timeout, cleared by the next accepted beat.
- beat_cnt  out  8  accepted-beat counter, wraps 255->0.

Behaviour:
- Reset (rst async or clr sync):
  - All outputs 0; state IDLE.
  - Tick divider, ibi_cnt, average window (4 entries, fill count) and peak_q all cleared.
- Edge detect:
  - peak_q registers peak.
  - rise = peak & ~peak_q.
  - A held-high peak yields one rise only.
- Tick divider:
  - div counts 0..TICK_DIV-1; tick = (div == TICK_DIV-1).
  - Free-running in all states.
- ibi_cnt:
  - Increments on tick in REFRACT and LISTEN; saturates at 2^IBI_W-1.
  - Held at 0 in IDLE.
- Registered outputs: all outputs are registered. beat and ibi_valid assert in the cycle after the clock edge where rise was sampled.
- FSM:
  - IDLE (initial, or after timeout):
    - On rise: beat=1, beat_cnt++, lost<=0, ibi_cnt<=0, refractory count<=0, go to REFRACT.
    - No ibi_valid on this first beat.
  - REFRACT:
    - rise ignored: no beat, no ibi update.
    - Refractory count increments on tick; when it reaches REFRACT, go to LISTEN.
    - ibi_cnt keeps counting.
  - LISTEN, on rise:
    - beat=1, ibi_valid=1, ibi<=ibi_cnt (value before any same-cycle increment).
    - Shift ibi_cnt into the window; fill count saturates at 4; avg_valid<=(fill==4 after push).
    - ibi_avg updates in the same cycle as ibi_valid, from the new window contents.
    - ibi_cnt<=0, beat_cnt++, go to REFRACT.
  - LISTEN, timeout (ibi_cnt reaches TIMEOUT with no rise):
    - lost<=1, window and fill cleared, avg_valid<=0, ibi_avg<=0, go to IDLE.
    - ibi holds its last value.
- Simultaneous events:
  - rise and tick in the same cycle: the rise wins; ibi captures the pre-increment count and the counter clears to 0.
  - rise in the cycle the timeout is reached: the beat is accepted and no timeout occurs.
  - clr and rise in the same cycle: clr wins; no beat.
- Window sum width: IBI_W+2 bits, so it cannot overflow.

Test Plan (TICK_DIV=4, REFRACT=5, TIMEOUT=40, IBI_W=8):
1. Reset mid-run (rst pulsed while in LISTEN with ibi=12, beat_cnt=3) -> all outputs 0 immediately, without waiting for a clock edge; the next rise is treated as a first beat (beat=1, ibi_valid=0).
2. First rise at cycle 10, then a second rise exactly 12 ticks (48 clks) later:
   - first rise -> beat=1 in cycle 11, ibi_valid=0, beat_cnt=1.
   - second rise -> beat=ibi_valid=1, ibi=12, beat_cnt=2.
3. Rise 3 ticks after an accepted beat (inside refractory) -> no beat, beat_cnt unchanged. A rise 10 ticks after that same beat -> ibi=10.
4. Peak held high for 100 clks -> exactly one beat.
5. Intervals 10, 12, 14, 16:
   - avg_valid=0 after the first three, 1 after the fourth, with ibi_avg=13.
   - A fifth interval of 20 -> ibi_avg=15 ((12+14+16+20)>>2).
6. No rise for 40 ticks after a beat -> lost=1, avg_valid=0, ibi_avg=0, ibi unchanged. The next rise -> beat=1, lost=0, ibi_valid=0.
